// File: rtl/out_serializer_if.sv
// out_serializer_if: upstream word bus, byte consumer handshake and status lines of the serializer.
interface out_serializer_if;
  logic [15:0] din;
  logic        din_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ack;
  logic        fifo_full;
  logic        overflow;
  logic [11:0] word_cnt;
  modport master (
    output din, din_ready, byte_ack,
    input  byte_out, byte_valid, fifo_full, overflow, word_cnt
  );
  modport slave (
    input  din, din_ready, byte_ack,
    output byte_out, byte_valid, fifo_full, overflow, word_cnt
  );
endinterface

// File: rtl/out_serializer.sv
// out_serializer: buffers 16-bit result words in a FIFO and emits them high byte first over a valid/ack byte port.
module out_serializer #(
  parameter int DEPTH = 8
) (
  input logic clock,
  input logic reset,
  out_serializer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, HI, LO} state_t;
  state_t      r_state;
  logic [15:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_count;
  logic [7:0]  r_shadow_lo, r_byte;
  logic        r_valid, r_full, r_ovf;
  logic [11:0] r_wc;
  logic        w_empty, w_full, w_load, w_write, w_drop;
  logic [AW:0] w_count_nxt;
  logic [15:0] w_head;
  assign w_empty = r_count == '0;
  assign w_full = r_count == FULL_CNT;
  assign w_head = r_mem[r_rd_ptr];
  // a load frees a slot on the same edge, so a full FIFO can still take a word then
  assign w_load = !w_empty && (r_state == IDLE || (r_state == LO && bus.byte_ack));
  assign w_write = bus.din_ready && (!w_full || w_load);
  assign w_drop = bus.din_ready && !w_write;
  assign w_count_nxt = r_count + {{AW{1'b0}}, w_write} - {{AW{1'b0}}, w_load};
  always_ff @(posedge clock)
    if (w_write) r_mem[r_wr_ptr] <= bus.din;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_shadow_lo <= 8'h00;
      r_byte <= 8'h00;
      r_valid <= 1'b0;
      r_full <= 1'b0;
      r_ovf <= 1'b0;
      r_wc <= 12'd0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full <= w_count_nxt == FULL_CNT;
      if (w_drop) r_ovf <= 1'b1;
      if (w_write && r_wc != 12'hFFF) r_wc <= r_wc + 12'd1;
      if (w_load) begin
        r_shadow_lo <= w_head[7:0];
        r_byte <= w_head[15:8];
        r_valid <= 1'b1;
        r_state <= HI;
      end else if (r_state == HI && bus.byte_ack) begin
        r_byte <= r_shadow_lo;
        r_state <= LO;
      end else if (r_state == LO && bus.byte_ack) begin
        r_valid <= 1'b0;
        r_state <= IDLE;
      end
    end
  assign bus.byte_out = r_byte;
  assign bus.byte_valid = r_valid;
  assign bus.fifo_full = r_full;
  assign bus.overflow = r_ovf;
  assign bus.word_cnt = r_wc;
endmodule

// File: tb/tb_out_serializer.sv
// tb_out_serializer: directed vector table, hand-written corner sequences and a queue-based reference model under random traffic.
module tb_out_serializer;
  localparam int D = 8;
  logic clock = 1'b0;
  logic reset = 1'b1;
  out_serializer_if bus();
  out_serializer #(.DEPTH(D)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  typedef struct {
    logic [15:0] din;
    logic        rdy;
    logic        ack;
    logic [7:0]  out;
    logic        chk_out;
    logic        valid;
    int          wc;
  } vec_t;
  vec_t vt[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] q[$];
  logic [7:0]  oq[$];
  bit m_ovf;
  int m_wc;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_clear;
    q.delete();
    oq.delete();
    m_ovf = 0;
    m_wc = 0;
  endtask
  // words wait in q, bytes still owed to the consumer wait in oq
  task automatic model_edge;
    logic [15:0] w;
    bit ld, wr;
    ld = q.size() > 0 && (oq.size() == 0 || (oq.size() == 1 && bus.byte_ack));
    wr = bus.din_ready && (q.size() < D || ld);
    if (oq.size() > 0 && bus.byte_ack) void'(oq.pop_front());
    if (ld) begin
      w = q.pop_front();
      oq.push_back(w[15:8]);
      oq.push_back(w[7:0]);
    end
    if (wr) begin
      q.push_back(bus.din);
      if (m_wc < 4095) m_wc++;
    end else if (bus.din_ready) m_ovf = 1;
  endtask
  task automatic check_model;
    chk("model_valid", bus.byte_valid, oq.size() > 0);
    if (oq.size() > 0) chk("model_byte", bus.byte_out, oq[0]);
    chk("model_full", bus.fifo_full, q.size() == D);
    chk("model_ovf", bus.overflow, m_ovf);
    chk("model_wc", bus.word_cnt, m_wc);
  endtask
  task automatic tick;
    model_edge();
    @(posedge clock);
    #1;
    check_model();
  endtask
  task automatic do_reset;
    reset = 1'b1;
    bus.din = 16'h0;
    bus.din_ready = 1'b0;
    bus.byte_ack = 1'b0;
    model_clear();
    #2;
    chk("rst_valid", bus.byte_valid, 0);
    chk("rst_byte", bus.byte_out, 0);
    chk("rst_full", bus.fifo_full, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_wc", bus.word_cnt, 0);
    @(negedge clock);
    reset = 1'b0;
  endtask
  task automatic add(logic [15:0] din, logic rdy, logic ack, logic [7:0] out, logic chk_out, logic valid, int wc);
    vt.push_back(vec_t'{din, rdy, ack, out, chk_out, valid, wc});
  endtask
  initial begin
    add(16'hA55A, 1, 1, 8'h00, 0, 0, 1);
    add(16'h0000, 0, 1, 8'hA5, 1, 1, 1);
    add(16'h0000, 0, 1, 8'h5A, 1, 1, 1);
    add(16'h0000, 0, 1, 8'h00, 0, 0, 1);
    add(16'h0102, 1, 0, 8'h00, 0, 0, 2);
    add(16'h0304, 1, 0, 8'h01, 1, 1, 3);
    add(16'h0506, 1, 0, 8'h01, 1, 1, 4);
    for (int i = 0; i < 7; i++) add(16'h0000, 0, 0, 8'h01, 1, 1, 4);
    add(16'h0000, 0, 1, 8'h02, 1, 1, 4);
    add(16'h0000, 0, 1, 8'h03, 1, 1, 4);
    add(16'h0000, 0, 1, 8'h04, 1, 1, 4);
    add(16'h0000, 0, 1, 8'h05, 1, 1, 4);
    add(16'h0000, 0, 1, 8'h06, 1, 1, 4);
    add(16'h0000, 0, 1, 8'h00, 0, 0, 4);
    do_reset();
    foreach (vt[i]) begin
      bus.din = vt[i].din;
      bus.din_ready = vt[i].rdy;
      bus.byte_ack = vt[i].ack;
      tick();
      if (vt[i].chk_out) chk($sformatf("vec%0d_byte", i), bus.byte_out, vt[i].out);
      chk($sformatf("vec%0d_valid", i), bus.byte_valid, vt[i].valid);
      chk($sformatf("vec%0d_wc", i), bus.word_cnt, vt[i].wc);
      chk($sformatf("vec%0d_ovf", i), bus.overflow, 0);
    end
    // overflow: stalled consumer, twelve offered words
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus.din = {8'(i + 1), 8'(i + 'h40)};
      bus.din_ready = 1'b1;
      tick();
      if (i == 7) chk("ovf_full_w8", bus.fifo_full, 0);
      if (i == 8) begin
        chk("ovf_full_w9", bus.fifo_full, 1);
        chk("ovf_clear_w9", bus.overflow, 0);
      end
      if (i == 9) chk("ovf_set_w10", bus.overflow, 1);
    end
    chk("ovf_wc", bus.word_cnt, 9);
    chk("ovf_head", bus.byte_out, 8'h01);
    // full FIFO, FSM in LO, ack and write on the same edge
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.din = {8'(i + 1), 8'(i + 'h40)};
      bus.din_ready = 1'b1;
      tick();
    end
    bus.din_ready = 1'b0;
    bus.byte_ack = 1'b1;
    tick();
    chk("fl_lo_byte", bus.byte_out, 8'h40);
    chk("fl_lo_full", bus.fifo_full, 1);
    bus.din = 16'hBEEF;
    bus.din_ready = 1'b1;
    tick();
    chk("fl_ld_full", bus.fifo_full, 1);
    chk("fl_ld_ovf", bus.overflow, 0);
    chk("fl_ld_wc", bus.word_cnt, 10);
    chk("fl_ld_byte", bus.byte_out, 8'h02);
    // asynchronous reset while in HI
    do_reset();
    bus.din = 16'h1111;
    bus.din_ready = 1'b1;
    tick();
    bus.din_ready = 1'b0;
    tick();
    chk("ar_hi_byte", bus.byte_out, 8'h11);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    chk("ar_valid", bus.byte_valid, 0);
    chk("ar_wc", bus.word_cnt, 0);
    chk("ar_full", bus.fifo_full, 0);
    #2;
    reset = 1'b0;
    bus.din = 16'h1234;
    bus.din_ready = 1'b1;
    bus.byte_ack = 1'b1;
    tick();
    bus.din_ready = 1'b0;
    tick();
    chk("ar_new_hi", bus.byte_out, 8'h12);
    tick();
    chk("ar_new_lo", bus.byte_out, 8'h34);
    tick();
    chk("ar_idle", bus.byte_valid, 0);
    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.din = 16'($urandom);
      bus.din_ready = $urandom_range(0, 3) != 0;
      bus.byte_ack = $urandom_range(0, 2) != 0;
      tick();
    end
    // continuous stream, long enough to saturate word_cnt
    do_reset();
    bus.din_ready = 1'b1;
    bus.byte_ack = 1'b1;
    for (int i = 0; i < 9000; i++) begin
      bus.din = 16'($urandom);
      tick();
    end
    chk("stream_ovf", bus.overflow, 1);
    chk("stream_wc_sat", bus.word_cnt, 4095);
    bus.din_ready = 1'b0;
    for (int i = 0; i < 2 * D + 4; i++) tick();
    chk("stream_drained", bus.byte_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
